// File: rtl/trdb_pkg.sv
// Trace encoder shared types: packet formats, sync subformats,
// scheduler request bundle and scheduler FSM states.
package trdb_pkg;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'h0,
        F_DIFF_DELTA = 2'h1,
        F_ADDR_ONLY  = 2'h2,
        F_SYNC       = 2'h3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'h0,
        SF_TRAP    = 2'h1,
        SF_CONTEXT = 2'h2,
        SF_SUPPORT = 2'h3
    } trdb_f_sync_subformat_e;

    typedef struct packed {
        trdb_format_e           format;
        trdb_f_sync_subformat_e subformat;
        logic                   thaddr;
        logic                   cause_mux;
        logic                   tval_mux;
    } trdb_pkt_req_t;

    typedef enum logic [1:0] {
        SCHED_OFF    = 2'h0,
        SCHED_ACTIVE = 2'h1,
        SCHED_DRAIN  = 2'h2
    } trdb_sched_state_e;

    // A support packet tells the decoder about losses, so it clears the flag.
    function automatic logic is_support_sync(input trdb_pkt_req_t p);
        return (p.format == F_SYNC) && (p.subformat == SF_SUPPORT);
    endfunction

endpackage

// File: rtl/trdb_sched_fifo.sv
// Synchronous request FIFO, DEPTH x trdb_pkt_req_t, wrap-bit pointers.
// Ports: clk_i, rst_ni, push_i, pop_i, data_i -> data_o (head), full_o, empty_o, one_o.
module trdb_sched_fifo
    import trdb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  trdb_pkt_req_t data_i,
    output trdb_pkt_req_t data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          one_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic [AW:0]   used;
    trdb_pkt_req_t mem_q [DEPTH];

    assign used    = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign one_o   = (used == PTR_ONE);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wptr_q[AW-1:0]] <= data_i;
                wptr_q                <= wptr_q + PTR_ONE;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/trdb_packet_sched.sv
// Packet scheduler: buffers selector requests, hands them to the emitter
// over valid/ready, owns the resync counter and the sticky packets-lost flag.
// Ports: clk_i, rst_ni, enable_i, req_* (request in), resync_rst_i,
//        pkt_valid_o/pkt_ready_i/pkt_o (emitter side), max_resync_o,
//        packets_lost_o, busy_o.
// Build option: TRDB_RESYNC_CYCLES_EN counts enabled cycles instead of pops.
module trdb_packet_sched
    import trdb_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESYNC_MAX = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   req_valid_i,
    input  trdb_format_e           req_format_i,
    input  trdb_f_sync_subformat_e req_subformat_i,
    input  logic                   req_thaddr_i,
    input  logic                   req_cause_mux_i,
    input  logic                   req_tval_mux_i,
    input  logic                   resync_rst_i,
    output logic                   pkt_valid_o,
    input  logic                   pkt_ready_i,
    output trdb_pkt_req_t          pkt_o,
    output logic                   max_resync_o,
    output logic                   packets_lost_o,
    output logic                   busy_o
);

    localparam int unsigned CW = $clog2(RESYNC_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RESYNC_MAX);
    localparam logic [CW-1:0] CNT_ONE = 1;

    trdb_sched_state_e state_q;
    trdb_pkt_req_t     req;
    trdb_pkt_req_t     head;
    logic              full;
    logic              empty;
    logic              one;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              drop;
    logic              inc;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              max_q;
    logic              lost_q;

    assign req.format    = req_format_i;
    assign req.subformat = req_subformat_i;
    assign req.thaddr    = req_thaddr_i;
    assign req.cause_mux = req_cause_mux_i;
    assign req.tval_mux  = req_tval_mux_i;

    assign pop      = !empty && pkt_ready_i;
    assign push_req = (state_q == SCHED_ACTIVE) && req_valid_i;
    // A full FIFO still takes the request when the head leaves this cycle.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    trdb_sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (req),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .one_o   (one)
    );

`ifdef TRDB_RESYNC_CYCLES_EN
    assign inc = (state_q != SCHED_OFF);
`else
    assign inc = pop;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SCHED_OFF || resync_rst_i) begin
            cnt_d = '0;
        end else if (inc && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SCHED_OFF;
        end else begin
            unique case (state_q)
                SCHED_OFF: begin
                    if (enable_i) state_q <= SCHED_ACTIVE;
                end
                SCHED_ACTIVE: begin
                    if (!enable_i) state_q <= SCHED_DRAIN;
                end
                SCHED_DRAIN: begin
                    if (enable_i) begin
                        state_q <= SCHED_ACTIVE;
                    end else if (empty || (pop && one)) begin
                        state_q <= SCHED_OFF;
                    end
                end
                default: state_q <= SCHED_OFF;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            max_q  <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            max_q <= (cnt_d == CNT_MAX);
            if (drop) begin
                lost_q <= 1'b1;
            end else if (pop && is_support_sync(head)) begin
                lost_q <= 1'b0;
            end
        end
    end

    assign pkt_valid_o    = !empty;
    assign pkt_o          = head;
    assign max_resync_o   = max_q;
    assign packets_lost_o = lost_q;
    assign busy_o         = (state_q != SCHED_OFF) || !empty;

endmodule
